// File: rtl/sbus_uart_rx.sv
// 8E2 serial receiver for the SBUS line: synchronise, optionally invert, sample mid-bit.
// Latency: strobe one cycle after the STOP2 sample; no backpressure, one strobe per character.
module sbus_uart_rx #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BIT_RATE = 100_000,
  parameter bit INVERT   = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rxd,
  output logic       uart_rx_valid,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_fe,
  output logic       uart_rx_pe
);

  localparam int CPB  = CLK_HZ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] CPB_M1   = CW'(CPB - 1);
  localparam logic          PIN_IDLE = INVERT ? 1'b0 : 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          pe_q, pe_d;
  logic          fe_q, fe_d;
  logic          sync1_q, sync2_q, rxd_q;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          ofe_q, ofe_d;
  logic          ope_q, ope_d;
  logic          rx;
  logic          at_half, at_full;

  assign rx      = INVERT ? ~sync2_q : sync2_q;
  assign at_half = (cnt_q == HALF_M1);
  assign at_full = (cnt_q == CPB_M1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= PIN_IDLE;
      sync2_q <= PIN_IDLE;
      rxd_q   <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      ofe_q   <= 1'b0;
      ope_q   <= 1'b0;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      rxd_q   <= rx;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ofe_q   <= ofe_d;
      ope_q   <= ope_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    valid_d = 1'b0;
    data_d  = data_q;
    ofe_d   = ofe_q;
    ope_d   = ope_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // Only a 1->0 transition starts a character, so a held-low line is ignored.
        if (rxd_q && !rx) state_d = S_START;
      end
      S_START: begin
        if (at_half) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (at_full) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (at_full) begin
          cnt_d   = '0;
          pe_d    = (^shift_q) ^ rx;
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (at_full) begin
          cnt_d   = '0;
          fe_d    = ~rx;
          state_d = S_STOP2;
        end
      end
      S_STOP2: begin
        if (at_full) begin
          // Return to idle at the sample so a zero-gap next start edge is caught.
          cnt_d   = '0;
          valid_d = 1'b1;
          data_d  = shift_q;
          ofe_d   = fe_q | ~rx;
          ope_d   = pe_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign uart_rx_valid = valid_q;
  assign uart_rx_data  = data_q;
  assign uart_rx_fe    = ofe_q;
  assign uart_rx_pe    = ope_q;

endmodule

// File: tb/tb_sbus_uart_rx.sv
// Bench for sbus_uart_rx: two instances (inverted and standard polarity), queue scoreboard.
module tb_sbus_uart_rx;

  localparam int CPB0 = 20, HALF0 = 10;
  localparam int CPB1 = 25, HALF1 = 12;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rxd0 = 1'b0;
  logic       rxd1 = 1'b1;
  logic       v0, fe0, pe0, v1, fe1, pe1;
  logic [7:0] d0, d1;

  sbus_uart_rx #(.CLK_HZ(2_000_000), .BIT_RATE(100_000), .INVERT(1'b1)) u_dut0 (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd0),
    .uart_rx_valid(v0), .uart_rx_data(d0), .uart_rx_fe(fe0), .uart_rx_pe(pe0)
  );

  sbus_uart_rx #(.CLK_HZ(2_500_000), .BIT_RATE(100_000), .INVERT(1'b0)) u_dut1 (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd1),
    .uart_rx_valid(v1), .uart_rx_data(d1), .uart_rx_fe(fe1), .uart_rx_pe(pe1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         at;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] last0 = 8'h00, last1 = 8'h00;
  int         n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cpb(input int inst);
    return (inst == 0) ? CPB0 : CPB1;
  endfunction

  function automatic int half(input int inst);
    return (inst == 0) ? HALF0 : HALF1;
  endfunction

  function automatic logic [7:0] dout(input int inst);
    return (inst == 0) ? d0 : d1;
  endfunction

  // Logical line level 1 = idle/mark; instance 0 sees it inverted at the pin.
  task automatic set_line(input int inst, input logic b);
    if (inst == 0) rxd0 = ~b;
    else           rxd1 = b;
  endtask

  task automatic bit_for(input int inst, input logic b, input int n);
    set_line(inst, b);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_char(input int inst, input logic [7:0] d, input logic par,
                           input logic s1, input logic s2);
    int   c0 = cyc;
    exp_t e;
    e.d  = d;
    e.fe = !(s1 && s2);
    e.pe = (^d) ^ par;
    // Start edge reaches synchronised rx two cycles after the pin changes.
    e.at = c0 + 2 + half(inst) + 11 * cpb(inst) + 1;
    if (inst == 0) begin q0.push_back(e); last0 = d; end
    else           begin q1.push_back(e); last1 = d; end
    bit_for(inst, 1'b0, cpb(inst));
    for (int k = 0; k < 8; k++) bit_for(inst, d[k], cpb(inst));
    bit_for(inst, par, cpb(inst));
    bit_for(inst, s1, cpb(inst));
    bit_for(inst, s2, cpb(inst));
  endtask

  task automatic take(input int inst, input logic [7:0] dat, input logic fe, input logic pe);
    exp_t e;
    if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL dut%0d unexpected strobe: got data %0h, required none", inst, dat);
    end else begin
      if (inst == 0) e = q0.pop_front();
      else           e = q1.pop_front();
      check($sformatf("dut%0d data", inst), {24'd0, dat}, {24'd0, e.d});
      check($sformatf("dut%0d fe", inst), {31'd0, fe}, {31'd0, e.fe});
      check($sformatf("dut%0d pe", inst), {31'd0, pe}, {31'd0, e.pe});
      check($sformatf("dut%0d strobe cycle", inst), cyc, e.at);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (v0 !== 1'b0) take(0, d0, fe0, pe0);
      if (v1 !== 1'b0) take(1, d1, fe1, pe1);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " dut0 valid"}, {31'd0, v0}, 32'd0);
    check({tag, " dut0 data"}, {24'd0, d0}, 32'd0);
    check({tag, " dut0 fe"}, {31'd0, fe0}, 32'd0);
    check({tag, " dut0 pe"}, {31'd0, pe0}, 32'd0);
    check({tag, " dut1 valid"}, {31'd0, v1}, 32'd0);
    check({tag, " dut1 data"}, {24'd0, d1}, 32'd0);
    check({tag, " dut1 fe"}, {31'd0, fe1}, 32'd0);
    check({tag, " dut1 pe"}, {31'd0, pe1}, 32'd0);
  endtask

  task automatic run(input int inst);
    logic [7:0] d;
    logic       par, s1, s2;
    int         gap, g;
    // Clean byte, then a parity error.
    send_char(inst, 8'h0F, 1'b0, 1'b1, 1'b1);
    bit_for(inst, 1'b1, 2 * cpb(inst));
    send_char(inst, 8'h00, 1'b1, 1'b1, 1'b1);
    bit_for(inst, 1'b1, 2 * cpb(inst));
    // Frame error followed by a long break: no retrigger while low.
    send_char(inst, 8'h25, ^8'h25, 1'b1, 1'b0);
    bit_for(inst, 1'b0, 5 * 12 * cpb(inst));
    bit_for(inst, 1'b1, 2 * cpb(inst));
    // Glitches shorter than half a bit.
    bit_for(inst, 1'b0, half(inst) - 3);
    bit_for(inst, 1'b1, 2 * cpb(inst));
    for (int i = 0; i < 3; i++) begin
      g = $urandom_range(half(inst) - 2, 1);
      bit_for(inst, 1'b0, g);
      bit_for(inst, 1'b1, 2 * cpb(inst));
    end
    check($sformatf("dut%0d data held after glitch", inst), {24'd0, dout(inst)},
          {24'd0, (inst == 0) ? last0 : last1});
    send_char(inst, 8'hA5, ^8'hA5, 1'b1, 1'b1);
    bit_for(inst, 1'b1, 2 * cpb(inst));
    // Full SBUS frame with zero inter-character gap.
    send_char(inst, 8'h0F, ^8'h0F, 1'b1, 1'b1);
    for (int b = 1; b <= 22; b++) begin
      d = 8'(b);
      send_char(inst, d, ^d, 1'b1, 1'b1);
    end
    send_char(inst, 8'h00, 1'b0, 1'b1, 1'b1);
    send_char(inst, 8'h00, 1'b0, 1'b1, 1'b1);
    bit_for(inst, 1'b1, 2 * cpb(inst));
    // Random characters with occasional parity and stop-bit errors.
    for (int i = 0; i < 30; i++) begin
      d   = 8'($urandom);
      par = ($urandom_range(3, 0) == 0) ? ~(^d) : (^d);
      s1  = ($urandom_range(4, 0) != 0);
      s2  = ($urandom_range(4, 0) != 0);
      gap = s2 ? $urandom_range(2, 0) : $urandom_range(2, 1);
      send_char(inst, d, par, s1, s2);
      if (gap > 0) bit_for(inst, 1'b1, gap * cpb(inst));
    end
    bit_for(inst, 1'b1, 2 * cpb(inst));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    #1;
    check({tag, " dut0 pending strobes"}, q0.size(), 32'd0);
    check({tag, " dut1 pending strobes"}, q1.size(), 32'd0);
  endtask

  task automatic reset_test(input int inst);
    // Leave nonzero outputs behind so the reset clear is observable.
    send_char(inst, 8'hC3, 1'b1, 1'b0, 1'b1);
    bit_for(inst, 1'b1, 2 * cpb(inst));
    drain("pre-reset");
    // Partial character: start, bits 0..3, then half of bit 4.
    bit_for(inst, 1'b0, cpb(inst));
    for (int k = 0; k < 4; k++) bit_for(inst, k[0], cpb(inst));
    bit_for(inst, 1'b1, cpb(inst) / 2);
    resetn = 1'b0;
    set_line(0, 1'b1);
    set_line(1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in reset");
    resetn = 1'b1;
    last0 = 8'h00;
    last1 = 8'h00;
    bit_for(inst, 1'b1, 14 * cpb(inst));
    check_reset_outputs("after reset");
    send_char(inst, 8'h3C, ^8'h3C, 1'b1, 1'b1);
    bit_for(inst, 1'b1, 2 * cpb(inst));
    drain("post-reset");
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    fork
      run(0);
      run(1);
    join
    drain("main");
    reset_test(0);
    reset_test(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
